// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - camera power-up sequencing, XCLK generation and windowed single-frame capture
// Define CAM_CTRL_TESTPAT_EN to replace each captured byte with {line[3:0], column[3:0]}.
module cam_capture_ctrl #(
  parameter int XCLK_DIV = 2,
  parameter int PWR_WAIT = 1000,
  parameter int RST_WAIT = 100,
  parameter int CAP_W    = 8,
  parameter int CAP_H    = 4
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ABORT,
  output logic       CAM_PWDN,
  output logic       CAM_RESET_N,
  output logic       CAM_XCLK,
  input  logic       CAM_VSYNC,
  input  logic       CAM_HREF,
  input  logic       CAM_PCLK,
  input  logic [7:0] CAM_D,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  input  logic       DATA_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVERRUN
);
  localparam int COL_W    = $clog2(CAP_W + 1);
  localparam int LINE_W   = $clog2(CAP_H + 1);
  localparam int WAIT_MAX = (PWR_WAIT > RST_WAIT) ? PWR_WAIT : RST_WAIT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int XDIV_W   = $clog2(XCLK_DIV + 1);

  typedef enum logic [2:0] {
    S_PWDN, S_RST, S_SETTLE, S_IDLE, S_WAIT_VS, S_WAIT_VE, S_CAP, S_DONE
  } stateT;

  stateT             state;
  logic [WAIT_W-1:0] waitCnt;
  logic [XDIV_W-1:0] xclkCnt;
  logic [COL_W-1:0]  colCnt;
  logic [LINE_W-1:0] lineCnt;

  logic [10:0] syncA, syncB;
  logic [2:0]  ctlPrev;
  logic        vsS, hrefS, pclkS;
  logic [7:0]  dS;
  logic        vsRise, vsFall, hrefFall, pclkRise;

  logic [7:0] fifoMem [4];
  logic [1:0] wrPtr, rdPtr;
  logic [2:0] fifoCnt;
  logic       capPush, popFire, fifoFull, writeOk, flush, startAccept;
  logic [7:0] capByte;

  // Control and data share one synchronizer so a sampled byte lines up with its PCLK edge.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      syncA   <= '0;
      syncB   <= '0;
      ctlPrev <= '0;
    end else begin
      syncA   <= {CAM_VSYNC, CAM_HREF, CAM_PCLK, CAM_D};
      syncB   <= syncA;
      ctlPrev <= syncB[10:8];
    end
  end

  assign vsS      = syncB[10];
  assign hrefS    = syncB[9];
  assign pclkS    = syncB[8];
  assign dS       = syncB[7:0];
  assign vsRise   = vsS & ~ctlPrev[2];
  assign vsFall   = ~vsS & ctlPrev[2];
  assign hrefFall = ~hrefS & ctlPrev[1];
  assign pclkRise = pclkS & ~ctlPrev[0];

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      xclkCnt  <= '0;
      CAM_XCLK <= 1'b0;
    end else if (xclkCnt == XDIV_W'(XCLK_DIV - 1)) begin
      xclkCnt  <= '0;
      CAM_XCLK <= ~CAM_XCLK;
    end else begin
      xclkCnt <= xclkCnt + XDIV_W'(1);
    end
  end

`ifdef CAM_CTRL_TESTPAT_EN
  assign capByte = {4'(lineCnt), 4'(colCnt)};
`else
  assign capByte = dS;
`endif

  assign capPush     = (state == S_CAP) & pclkRise & hrefS & (colCnt < COL_W'(CAP_W));
  assign DATA_VALID  = (fifoCnt != 3'd0);
  assign DATA        = fifoMem[rdPtr];
  assign popFire     = DATA_VALID & DATA_READY;
  assign fifoFull    = (fifoCnt == 3'd4);
  assign writeOk     = capPush & (~fifoFull | popFire);
  assign flush       = ABORT & ((state == S_WAIT_VS) | (state == S_WAIT_VE) | (state == S_CAP));
  assign startAccept = START & (state == S_IDLE);

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) fifoMem[i] <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
      OVERRUN <= 1'b0;
    end else begin
      if (flush) begin
        wrPtr   <= '0;
        rdPtr   <= '0;
        fifoCnt <= '0;
      end else begin
        if (writeOk) begin
          fifoMem[wrPtr] <= capByte;
          wrPtr          <= wrPtr + 2'd1;
        end
        if (popFire) rdPtr <= rdPtr + 2'd1;
        fifoCnt <= fifoCnt + 3'(writeOk) - 3'(popFire);
      end
      if (startAccept) OVERRUN <= 1'b0;
      else if (capPush & fifoFull & ~popFire) OVERRUN <= 1'b1;
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_PWDN;
      waitCnt     <= '0;
      colCnt      <= '0;
      lineCnt     <= '0;
      CAM_PWDN    <= 1'b1;
      CAM_RESET_N <= 1'b0;
      BUSY        <= 1'b1;
      DONE        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_PWDN:
          if (waitCnt == WAIT_W'(PWR_WAIT - 1)) begin
            waitCnt  <= '0;
            CAM_PWDN <= 1'b0;
            state    <= S_RST;
          end else waitCnt <= waitCnt + WAIT_W'(1);
        S_RST:
          if (waitCnt == WAIT_W'(RST_WAIT - 1)) begin
            waitCnt     <= '0;
            CAM_RESET_N <= 1'b1;
            state       <= S_SETTLE;
          end else waitCnt <= waitCnt + WAIT_W'(1);
        S_SETTLE:
          if (waitCnt == WAIT_W'(RST_WAIT - 1)) begin
            waitCnt <= '0;
            BUSY    <= 1'b0;
            state   <= S_IDLE;
          end else waitCnt <= waitCnt + WAIT_W'(1);
        S_IDLE:
          if (START) begin
            BUSY  <= 1'b1;
            state <= S_WAIT_VS;
          end
        S_WAIT_VS:
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else if (vsRise) state <= S_WAIT_VE;
        S_WAIT_VE:
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else if (vsFall) begin
            colCnt  <= '0;
            lineCnt <= '0;
            state   <= S_CAP;
          end
        S_CAP:
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else if (lineCnt == LINE_W'(CAP_H) || vsRise) begin
            DONE  <= 1'b1;
            state <= S_DONE;
          end else if (hrefFall) begin
            lineCnt <= lineCnt + LINE_W'(1);
            colCnt  <= '0;
          end else if (capPush) begin
            colCnt <= colCnt + COL_W'(1);
          end
        S_DONE: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
